// File: rtl/shift_pkg.sv
// Shared types for the ALU barrel shifter: operation encoding and field widths.
package shift_pkg;

   localparam int unsigned SHIFT_OP_W = 2;

   typedef enum logic [SHIFT_OP_W-1:0] {
      SHIFT_SLL  = 2'd0,
      SHIFT_SRL  = 2'd1,
      SHIFT_SRA  = 2'd2,
      SHIFT_PASS = 2'd3
   } shift_op_e;

endpackage

// File: rtl/shift_barrel.sv
// Combinational log2(WIDTH_P)-stage barrel shifter. Right shifts fill with `fill`;
// left shifts run through the same right stages with bit-reversed input and output.
module shift_barrel #(
   parameter int unsigned WIDTH_P       = 32,
   parameter int unsigned SHAMT_WIDTH_P = $clog2(WIDTH_P)
) (
   input  logic [WIDTH_P-1:0]       data,
   input  logic [SHAMT_WIDTH_P-1:0] shamt,
   input  logic                     right,
   input  logic                     fill,
   output logic [WIDTH_P-1:0]       result
);

   logic [WIDTH_P-1:0] rev_in;
   logic [WIDTH_P-1:0] rev_out;
   logic [WIDTH_P-1:0] stage [SHAMT_WIDTH_P+1];

   for (genvar i = 0; i < WIDTH_P; i++) begin : g_rev_in
      assign rev_in[i] = data[WIDTH_P-1-i];
   end

   assign stage[0] = right ? data : rev_in;

   // Stage s shifts right by 2**s when shamt[s] is set.
   for (genvar s = 0; s < SHAMT_WIDTH_P; s++) begin : g_stage
      localparam int unsigned STEP = 2 ** s;
      assign stage[s+1] = shamt[s] ? {{STEP{fill}}, stage[s][WIDTH_P-1:STEP]} : stage[s];
   end

   for (genvar i = 0; i < WIDTH_P; i++) begin : g_rev_out
      assign rev_out[i] = stage[SHAMT_WIDTH_P][WIDTH_P-1-i];
   end

   assign result = right ? stage[SHAMT_WIDTH_P] : rev_out;

endmodule

// File: rtl/shift_unit.sv
// ALU shifter: SLL/SRL/SRA/PASS. Define SHIFT_UNIT_REG_OUT_EN for a registered
// output (latency 1); otherwise the result path is purely combinational.
module shift_unit
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH_P       = 32,
   parameter int unsigned SHAMT_WIDTH_P = $clog2(WIDTH_P)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     valid_i,
   input  logic [WIDTH_P-1:0]       data_i,
   input  logic [SHAMT_WIDTH_P-1:0] shamt_i,
   input  logic [SHIFT_OP_W-1:0]    op_i,
   output logic                     valid_o,
   output logic [WIDTH_P-1:0]       shift_o
);

   shift_op_e          op;
   logic               right_c;
   logic               fill_c;
   logic [WIDTH_P-1:0] barrel_c;
   logic [WIDTH_P-1:0] result_c;

   // Every 2-bit code maps to an enumerator, so the cast is total.
   assign op      = shift_op_e'(op_i);
   assign right_c = (op != SHIFT_SLL);
   assign fill_c  = (op == SHIFT_SRA) & data_i[WIDTH_P-1];

   shift_barrel #(
      .WIDTH_P       (WIDTH_P),
      .SHAMT_WIDTH_P (SHAMT_WIDTH_P)
   ) u_barrel (
      .data   (data_i),
      .shamt  (shamt_i),
      .right  (right_c),
      .fill   (fill_c),
      .result (barrel_c)
   );

   assign result_c = (op == SHIFT_PASS) ? data_i : barrel_c;

`ifdef SHIFT_UNIT_REG_OUT_EN
   // Result register: loads on valid, holds otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         shift_o <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            shift_o <= result_c;
         end
      end
   end
`else
   logic unused_clk_rst;

   assign unused_clk_rst = clk_i ^ rst_ni;
   assign valid_o        = valid_i;
   assign shift_o        = result_c;
`endif

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit; follows the registered or combinational
// build according to SHIFT_UNIT_REG_OUT_EN.
module tb_shift_unit;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic [31:0] data;
   logic [4:0]  shamt;
   logic [1:0]  op;
   logic        valid_out;
   logic [31:0] shift_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp = 32'h0;

   shift_unit #(.WIDTH_P(32)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i (valid),
      .data_i  (data),
      .shamt_i (shamt),
      .op_i    (op),
      .valid_o (valid_out),
      .shift_o (shift_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                             input logic [1:0] o);
      case (o)
         2'd0:    return d << s;
         2'd1:    return d >> s;
         2'd2:    return 32'($signed(d) >>> s);
         default: return d;
      endcase
   endfunction

   // Apply one cycle of stimulus at negedge, then wait to the sample point.
   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] o, input logic [31:0] expv);
      @(negedge clk);
      valid = v;
      data  = d;
      shamt = s;
      op    = o;
      if (v) exp_q.push_back(expv);
`ifdef SHIFT_UNIT_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      data  = 32'hA5A5_5A5A;
      shamt = 5'd3;
      op    = 2'd0;
      #12;
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", valid_out);
      end
`ifdef SHIFT_UNIT_REG_OUT_EN
      checks++;
      if (shift_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_shift: got %h want 00000000", shift_out);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] td [12] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h0123_4567, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001,
                               32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
      logic [4:0]  ts [12] = '{5'd0, 5'd1, 5'd1, 5'd31, 5'd16, 5'd4, 5'd4, 5'd7,
                               5'd31, 5'd31, 5'd31, 5'd0};
      logic [1:0]  to [12] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3,
                               2'd1, 2'd0, 2'd2, 2'd2};
      logic [31:0] te [12] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                               32'h4567_0000, 32'h0DEA_DBEE, 32'hFDEA_DBEE, 32'h0000_0001,
                               32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'hDEAD_BEEF};
      logic [31:0] e;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, td[i], ts[i], to[i], te[i]);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL directed_%0d: scoreboard empty", i);
         end else begin
            e = exp_q.pop_front();
            last_exp = e;
            if (shift_out !== e || valid_out !== 1'b1) begin
               errors++;
               $display("FAIL directed_%0d: got %h/v%b want %h/v1", i, shift_out, valid_out, e);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  o;
      logic [31:0] e;
      for (int i = 0; i < 160; i++) begin
         d = $urandom;
         s = 5'($urandom_range(0, 31));
         o = (i < 150) ? 2'($urandom_range(0, 2)) : 2'd3;
         drive(1'b1, d, s, o, ref_shift(d, s, o));
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL random_%0d: scoreboard empty", i);
         end else begin
            e = exp_q.pop_front();
            last_exp = e;
            if (shift_out !== e || valid_out !== 1'b1) begin
               errors++;
               $display("FAIL random_%0d: d=%h s=%0d op=%0d got %h/v%b want %h/v1",
                        i, d, s, o, shift_out, valid_out, e);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [4:0]  s;
      logic [31:0] e;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         s = 5'(i * 2 + 1);
         @(negedge clk);
         valid = 1'b1;
         data  = d;
         shamt = s;
         op    = 2'(i % 3);
         exp_q.push_back(ref_shift(d, s, 2'(i % 3)));
`ifdef SHIFT_UNIT_REG_OUT_EN
         #1;
         checks++;
         if (shift_out !== last_exp) begin
            errors++;
            $display("FAIL b2b_early_%0d: got %h want %h", i, shift_out, last_exp);
         end
         @(posedge clk);
`endif
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_%0d: scoreboard empty", i);
         end else begin
            e = exp_q.pop_front();
            last_exp = e;
            if (shift_out !== e || valid_out !== 1'b1) begin
               errors++;
               $display("FAIL b2b_%0d: got %h/v%b want %h/v1", i, shift_out, valid_out, e);
            end
         end
      end
   endtask

   task automatic test_hold();
      logic [31:0] d;
      logic [4:0]  s;
      logic [31:0] want;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         s = 5'($urandom_range(1, 31));
         drive(1'b0, d, s, 2'd1, 32'h0);
`ifdef SHIFT_UNIT_REG_OUT_EN
         want = last_exp;
`else
         want = ref_shift(d, s, 2'd1);
`endif
         checks++;
         if (valid_out !== 1'b0 || shift_out !== want) begin
            errors++;
            $display("FAIL hold_%0d: got %h/v%b want %h/v0", i, shift_out, valid_out, want);
         end
      end
   endtask

   task automatic test_mid_reset();
`ifdef SHIFT_UNIT_REG_OUT_EN
      logic [31:0] e;
      drive(1'b1, 32'hF0F0_1234, 5'd4, 2'd2, 32'hFF0F_0123);
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if (shift_out !== e || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: got %h/v%b want %h/v1", shift_out, valid_out, e);
      end
      @(negedge clk);
      valid = 1'b1;
      data  = 32'h1234_5678;
      shamt = 5'd8;
      op    = 2'd0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (shift_out !== 32'h0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got %h/v%b want 00000000/v0", shift_out, valid_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (shift_out !== 32'h0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_hold: got %h/v%b want 00000000/v0", shift_out, valid_out);
      end
      last_exp = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'h1234_5678, 5'd8, 2'd0, 32'h3456_7800);
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if (shift_out !== e || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_post: got %h/v%b want %h/v1", shift_out, valid_out, e);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_hold();
      test_mid_reset();
      test_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
